// File: rtl/rotate_controller.sv
// Sequencer for the rho-step rotate datapath: walks 25 lanes x 64 slices,
// issuing a stage/commit strobe pair per slice under counter carry-out control.
module rotate_controller (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic stall,
  input  logic cnt_co_64,
  input  logic cnt_co_25,
  output logic wr_en_1,
  output logic wr_en_2,
  output logic inreg_en,
  output logic cnt_en_64,
  output logic cnt_en_25,
  output logic cnt_rst_64,
  output logic cnt_rst_25,
  output logic busy,
  output logic done
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_INIT      = 3'd1;
  localparam logic [2:0] S_STAGE     = 3'd2;
  localparam logic [2:0] S_COMMIT    = 3'd3;
  localparam logic [2:0] S_NEXT_LANE = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  logic [2:0] state;
  logic [2:0] state_next;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Handshake: start is a request taken only in IDLE (no queuing while busy);
  // done is a single-cycle pulse, after which one IDLE cycle always follows.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (start) state_next = S_INIT;
      S_INIT:      state_next = S_STAGE;
      S_STAGE:     if (!stall) state_next = S_COMMIT;
      S_COMMIT:    if (!stall) state_next = cnt_co_64 ? S_NEXT_LANE : S_STAGE;
      S_NEXT_LANE: if (!stall) state_next = cnt_co_25 ? S_DONE : S_STAGE;
      S_DONE:      state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  // Outputs are forced low while rst is held so a mid-pass reset is silent at once.
  always_comb begin
    wr_en_1    = 1'b0;
    wr_en_2    = 1'b0;
    inreg_en   = 1'b0;
    cnt_en_64  = 1'b0;
    cnt_en_25  = 1'b0;
    cnt_rst_64 = 1'b0;
    cnt_rst_25 = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    if (!rst) begin
      busy = (state != S_IDLE);
      case (state)
        S_INIT: begin
          cnt_rst_64 = 1'b1;
          cnt_rst_25 = 1'b1;
        end
        S_STAGE: if (!stall) begin
          wr_en_1  = 1'b1;
          inreg_en = 1'b1;
        end
        S_COMMIT: if (!stall) begin
          wr_en_2   = 1'b1;
          cnt_en_64 = 1'b1;
        end
        // Lane advance is suppressed on the final lane so the counter parks at 31.
        S_NEXT_LANE: if (!stall) begin
          cnt_rst_64 = 1'b1;
          cnt_en_25  = !cnt_co_25;
        end
        S_DONE:  done = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rotate_controller.sv
// Bench for rotate_controller: models the slice/lane counters, predicts done
// timing from pass length plus stall cycles, and checks strobe totals per pass.
module tb_rotate_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic stall = 1'b0;
  logic cnt_co_64, cnt_co_25;
  logic wr_en_1, wr_en_2, inreg_en, cnt_en_64, cnt_en_25;
  logic cnt_rst_64, cnt_rst_25, busy, done;

  rotate_controller dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .cnt_co_64(cnt_co_64), .cnt_co_25(cnt_co_25),
    .wr_en_1(wr_en_1), .wr_en_2(wr_en_2), .inreg_en(inreg_en),
    .cnt_en_64(cnt_en_64), .cnt_en_25(cnt_en_25),
    .cnt_rst_64(cnt_rst_64), .cnt_rst_25(cnt_rst_25),
    .busy(busy), .done(done)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // datapath counter models
  logic [5:0] slice_m = 6'd0;
  logic [4:0] lane_m = 5'd0;
  always @(posedge clk) begin
    if (cnt_rst_64) slice_m <= 6'd0;
    else if (cnt_en_64) slice_m <= slice_m + 6'd1;
    if (cnt_rst_25) lane_m <= 5'd7;
    else if (cnt_en_25) lane_m <= lane_m + 5'd1;
  end
  assign cnt_co_64 = (slice_m == 6'd63);
  assign cnt_co_25 = (lane_m == 5'd31);

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard state: exp_q holds the expected done cycle of the open pass
  logic [31:0] exp_q[$];
  bit exp_idle = 1'b1;
  bit prev_rst = 1'b0;
  bit last_lane_prev = 1'b0;
  bit pending_stage = 1'b0;
  int pass_t = 0;
  int n_wr1, n_wr2, n_en64, n_en25, n_nl, n_init, lane_commits;
  int last_len = 0, last_done = 0, prev_done = 0, done_count = 0;

  // driver
  task automatic step(input logic s, input logic st, input logic r);
    @(negedge clk);
    start = s;
    stall = st;
    rst   = r;
    if (s && !r && exp_idle) exp_q.push_back(32'(cyc + 3227));
    #2;
  endtask

  // monitor
  task automatic monitor_cycle();
    int c;
    bit done_now;
    c = cyc;
    done_now = 1'b0;
    if (rst || prev_rst) begin
      check("reset_outputs", int'({busy, done, wr_en_1, wr_en_2, inreg_en, cnt_en_64,
                                   cnt_en_25, cnt_rst_64, cnt_rst_25}), 0);
    end else begin
      check("busy", int'(busy), int'(!exp_idle));
      check("wr_exclusive", int'(wr_en_1 && wr_en_2), 0);
      if (exp_idle) begin
        check("idle_outputs", int'({done, wr_en_1, wr_en_2, inreg_en, cnt_en_64,
                                    cnt_en_25, cnt_rst_64, cnt_rst_25}), 0);
      end else begin
        check("inreg_with_stage", int'(inreg_en), int'(wr_en_1));
        check("slice_inc_with_commit", int'(cnt_en_64), int'(wr_en_2));
        if (c == pass_t + 1)
          check("init_resets", int'({cnt_rst_64, cnt_rst_25}), 3);
        else if (stall)
          check("stall_quiet", int'({wr_en_1, wr_en_2, inreg_en, cnt_en_64,
                                     cnt_en_25, cnt_rst_64}), 0);
        if (last_lane_prev) check("done_after_last_lane", int'(done), 1);
        last_lane_prev = 1'b0;
        n_wr1 += int'(wr_en_1);
        n_wr2 += int'(wr_en_2);
        n_en64 += int'(cnt_en_64);
        n_en25 += int'(cnt_en_25);
        n_init += int'(cnt_rst_25);
        if (wr_en_1) begin
          check("stage_order", int'(pending_stage), 0);
          pending_stage = 1'b1;
        end
        if (wr_en_2) begin
          check("commit_order", int'(pending_stage), 1);
          pending_stage = 1'b0;
          check("slice_seq", int'(slice_m), lane_commits);
          lane_commits++;
        end
        if (cnt_rst_64 && !cnt_rst_25) begin
          n_nl++;
          check("lane_commits", lane_commits, 64);
          lane_commits = 0;
          check("lane_advance", int'(cnt_en_25), int'(lane_m != 5'd31));
          if (lane_m == 5'd31) last_lane_prev = 1'b1;
        end
      end
      // a stall after INIT and before DONE delays completion by one cycle
      if (!exp_idle && stall && exp_q.size() > 0 && c >= pass_t + 2 && c < int'(exp_q[0]))
        exp_q[0] = exp_q[0] + 32'd1;
      if (done) begin
        if (exp_q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          check("done_cycle", c, int'(exp_q.pop_front()));
          done_now = 1'b1;
        end
      end else if (exp_q.size() > 0 && int'(exp_q[0]) <= c) begin
        check("done_missing", 0, 1);
        void'(exp_q.pop_front());
        done_now = 1'b1;
      end
      if (done_now) begin
        check("wr1_total", n_wr1, 1600);
        check("wr2_total", n_wr2, 1600);
        check("en64_total", n_en64, 1600);
        check("en25_total", n_en25, 24);
        check("next_lane_total", n_nl, 25);
        check("init_count", n_init, 1);
        last_len = c - pass_t;
        prev_done = last_done;
        last_done = c;
        done_count++;
      end
    end
    if (rst) begin
      exp_idle = 1'b1;
      exp_q.delete();
      last_lane_prev = 1'b0;
    end else if (exp_idle && start) begin
      exp_idle = 1'b0;
      pass_t = c;
      n_wr1 = 0; n_wr2 = 0; n_en64 = 0; n_en25 = 0; n_nl = 0; n_init = 0;
      lane_commits = 0;
      pending_stage = 1'b0;
    end else if (done_now) begin
      exp_idle = 1'b1;
    end
    prev_rst = rst;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #1;
      monitor_cycle();
    end
  end

  // one pass: mode 0 nominal with ignored starts, 1 directed stalls, 2 random
  task automatic run_pass(input int mode);
    int k;
    logic s, st;
    step(1'b1, 1'b0, 1'b0);
    k = 1;
    while (k < 4000) begin
      st = 1'b0;
      s = 1'b0;
      if (mode == 0) s = (k == 1500 || k == 3227);
      if (mode == 1) st = (k inside {1, 12, 13, 14, 26, 27, 135, 136, 137, 138});
      if (mode == 2) begin
        st = ($urandom_range(0, 7) == 0);
        s = ($urandom_range(0, 499) == 0);
      end
      step(s, st, 1'b0);
      k++;
      if (exp_idle) break;
    end
    if (k >= 4000) check("pass_timeout", 0, 1);
  endtask

  initial begin
    int d0, n;
    repeat (3) step(1'b0, 1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b0, 1'b0);

    run_pass(0);
    check("nominal_len", last_len, 3227);
    check("single_done", done_count, 1);
    repeat (3) step(1'b0, 1'b0, 1'b0);

    run_pass(1);
    check("stall_len", last_len, 3236);
    repeat (2) step(1'b0, 1'b0, 1'b0);

    run_pass(2);
    repeat (2) step(1'b0, 1'b0, 1'b0);

    // reset at slice 40 of lane 12
    d0 = done_count;
    step(1'b1, 1'b0, 1'b0);
    n = 0;
    while (!(lane_m == 5'd12 && slice_m == 6'd40) && n < 4000) begin
      step(1'b0, 1'b0, 1'b0);
      n++;
    end
    if (n >= 4000) check("reset_point_timeout", 0, 1);
    step(1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    check("no_done_after_reset", done_count, d0);
    run_pass(0);
    check("post_reset_len", last_len, 3227);

    // start held high: back-to-back passes
    d0 = done_count;
    n = 0;
    while (done_count < d0 + 2 && n < 8000) begin
      step(1'b1, 1'b0, 1'b0);
      n++;
    end
    if (n >= 8000) check("b2b_timeout", 0, 1);
    repeat (4) step(1'b0, 1'b0, 1'b0);
    check("b2b_spacing", last_done - prev_done, 3228);
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rotate_controller.md
# rotate_controller

Sequencing FSM for the rotate (rho-step) datapath. On a `start` pulse it walks all 25 lanes and, within each lane, all 64 slice positions. It drives the datapath's two write strobes, the input-register enable, and the lane/slice counter enables and resets, using the counters' carry-outs as loop terminators. It reports `busy` and pulses `done` on completion, and it sits between the top-level encoder controller and the rotate datapath.

## Interface
- No parameters. Loop bounds are fixed by the datapath counters: the 6-bit slice counter runs 0..63; the 5-bit lane counter resets to 7 and runs 7..31, which is 25 lanes.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin one full rotate pass; sampled only in IDLE.
- `stall` in 1: freeze request; honoured in STAGE, COMMIT and NEXT_LANE.
- `cnt_co_64` in 1: slice-counter carry-out; high when the slice count is 63.
- `cnt_co_25` in 1: lane-counter carry-out; high when the lane count is 31.
- `wr_en_1` out 1: stage strobe (read/rotate the current slice).
- `wr_en_2` out 1: commit strobe (write the rotated slice back).
- `inreg_en` out 1: input line register load enable.
- `cnt_en_64` out 1: slice counter increment.
- `cnt_en_25` out 1: lane counter increment.
- `cnt_rst_64` out 1: slice counter reset (to 0).
- `cnt_rst_25` out 1: lane counter reset (to 7).
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.

## Operation
- States: IDLE, INIT, STAGE, COMMIT, NEXT_LANE, DONE.
- IDLE
  - All strobes are 0.
  - `start`=1 → INIT; otherwise stay.
- INIT
  - `cnt_rst_64`=1 and `cnt_rst_25`=1.
  - Always → STAGE; `stall` is ignored here.
- STAGE
  - `wr_en_1`=1 and `inreg_en`=1.
  - Always → COMMIT.
- COMMIT
  - `wr_en_2`=1 and `cnt_en_64`=1.
  - `cnt_co_64`=0 → STAGE; `cnt_co_64`=1 → NEXT_LANE.
  - The increment at slice 63 wraps the slice counter to 0.
- NEXT_LANE
  - `cnt_rst_64`=1 (defensive re-zero of the slice counter).
  - `cnt_co_25`=1 → DONE.
  - Otherwise `cnt_en_25`=1 → STAGE.
- DONE
  - `done`=1 for exactly one cycle.
  - Always → IDLE; `start` is ignored here.
- Stall
  - While `stall`=1 in STAGE, COMMIT or NEXT_LANE, the state is held.
  - During a stall, `wr_en_1`, `wr_en_2`, `inreg_en`, `cnt_en_64`, `cnt_en_25` and `cnt_rst_64` are forced to 0; `busy` stays 1.
  - Work resumes in the held state on the first cycle with `stall`=0. No strobe is ever issued twice for the same slice.
- Output decoding: outputs depend on state and `stall` only. Counter carry-outs affect only next-state logic, never outputs in the same cycle, except `cnt_en_25` in NEXT_LANE.
- Write ordering: `wr_en_1` and `wr_en_2` are never high in the same cycle. Each slice gets exactly one STAGE followed by exactly one COMMIT.
- Reset
  - `rst`=1 forces IDLE at the next edge, from any state including mid-pass.
  - `busy`, `done` and all strobes are 0 during and after reset. The partial pass is abandoned.
  - The next `start` re-runs INIT, so the counters are reinitialised.
- `start` while `busy`=1 is ignored, with no queuing.

## Timing
- Reset values: all outputs 0; state IDLE.
- With `start` sampled high in IDLE at edge t:
  - INIT occupies cycle t+1.
  - The first STAGE occupies cycle t+2.
- Per lane: 64 × (STAGE+COMMIT) + 1 NEXT_LANE = 129 cycles.
- `done` is high in cycle t+3227 (1 INIT + 25×129 + 1), with zero stalls.
- Each stall cycle adds exactly 1 cycle of latency.
- `busy` rises in cycle t+1 and falls at the first IDLE cycle after DONE.
- `start` may be reasserted in the IDLE cycle after DONE; back-to-back passes are separated by exactly that one IDLE cycle.
- Totals per pass: 1600 `wr_en_1` pulses, 1600 `wr_en_2` pulses, 1600 `cnt_en_64` pulses, 24 `cnt_en_25` pulses, 25 NEXT_LANE cycles.

## Test plan
- Nominal pass: model both counters in the bench and pulse `start`. Require `done` at t+3227, the strobe counts given above, and `busy` high for 3227 cycles.
- Lane boundary: check the slice counter holds 0..63 during each lane's COMMITs, and that `cnt_en_25` pulses when the lane count is 7..30. Require no `cnt_en_25` when the lane count is 31, and DONE to follow that NEXT_LANE.
- Stall injection:
  - Assert `stall` for 3 cycles in a STAGE, 2 in a COMMIT and 4 in a NEXT_LANE.
  - Require `done` at t+3236.
  - Require all strobes 0 while stalled and the strobe totals unchanged.
- Reset mid-pass: assert `rst` for one cycle at slice 40 of lane 12. Require all outputs 0 on the next cycle, then a fresh `start` giving a full 3227-cycle pass beginning with INIT counter resets.
- Ignored start: pulse `start` during the pass and during DONE. Require no extra INIT and exactly one `done`.
- Back-to-back: `start` held high continuously. Require `done` pulses 3228 cycles apart, each preceded by exactly one IDLE cycle.
